axis_tx_pkt_buffer: RTL and testbench
=====================================

// Module: axis_tx_pkt_buffer
// PURPOSE
//  Store-and-forward byte buffer feeding the Ethernet/UDP transmitter. Accepts one
//  AXI-Stream payload packet from user logic, counts its bytes, then replays it with
//  the byte count on m_axis_tuser_o, held stable for the whole packet, so the
//  transmitter can build IP/UDP length fields before the first payload byte.
// PARAMETERS
//  MAX_BYTES   1472  max payload bytes per packet (UDP payload over 1500 MTU); buffer depth
//  LEN_W       12    width of length field on m_axis_tuser_o; MAX_BYTES < 2**LEN_W
// PORTS
//  clk_i            in   1      single clock for all logic
//  rst_ni           in   1      asynchronous, active-low reset
//  s_axis_tvalid_i  in   1      upstream byte valid
//  s_axis_tdata_i   in   8      upstream payload byte
//  s_axis_tlast_i   in   1      last byte of upstream packet
//  s_axis_tready_o  out  1      buffer accepting bytes
//  m_axis_tvalid_o  out  1      byte valid to transmitter
//  m_axis_tdata_o   out  8      payload byte
//  m_axis_tlast_o   out  1      last byte of packet
//  m_axis_tuser_o   out  LEN_W  packet byte count, constant while packet is in flight
//  m_axis_tready_i  in   1      transmitter ready
//  drop_o           out  1      one-cycle pulse: oversize packet handled (see CONFIGURATION)
// BEHAVIOUR
//  Reset: all outputs 0 except s_axis_tready_o=1 one cycle after rst_ni deasserts
//   (0 while rst_ni=0); write pointer, length and state cleared. Reset mid-packet
//   discards the partial or in-flight packet; no output glitches once rst_ni rises.
//  Handshake: transfer on tvalid&&tready. m_axis_tvalid_o, once high, stays high with
//   stable tdata/tlast/tuser until accepted.
//  FSM FILL: s_axis_tready_o=1. Each accepted byte goes to buf[wr_ptr], wr_ptr++.
//   Accepted byte with tlast: len<=wr_ptr+1, then -> LOAD.
//  FSM LOAD (1 cycle): s_axis_tready_o=0; issue synchronous RAM read of buf[0].
//   -> SEND. First m_axis_tvalid_o rises 2 cycles after the input tlast handshake.
//  FSM SEND: s_axis_tready_o=0; output register holds buf[rd_ptr], prefetching next byte
//   so back-to-back output at 1 byte/cycle when m_axis_tready_i held high.
//   m_axis_tlast_o=1 exactly when rd_ptr==len-1. On tlast handshake: tvalid drops the
//   next cycle, pointers clear -> FILL (s_axis_tready_o=1 next cycle).
//  m_axis_tready_i low in SEND: output holds; no byte skipped or repeated.
//  Buffer full: input byte number MAX_BYTES without tlast is the oversize case
//   (CONFIGURATION). Minimum packet is 1 byte (tlast on first byte): tuser=1, tlast
//   with first output.
//  Single buffer: upstream is backpressured for the whole SEND phase.
//  Width rules: wr_ptr/rd_ptr/len are LEN_W bits unsigned; no wrap occurs, since
//   max count==MAX_BYTES.
// CONFIGURATION
//  AXIS_TX_PKT_BUFFER_DROP_OVERSIZE_EN
//   undefined: byte number MAX_BYTES is accepted as a forced last byte. len=MAX_BYTES,
//    -> LOAD, drop_o pulses. Later input bytes form the next packet.
//   defined: on byte number MAX_BYTES without tlast, enter DROP. DROP keeps
//    s_axis_tready_o=1 and discards bytes through the input tlast, then pulses drop_o
//    and returns to FILL with pointers cleared. Nothing is emitted for that packet.
// TESTING
//  1) 4-byte pkt 11,22,33,44 (tlast on 44), m_tready=1 -> out 11,22,33,44 tuser=4
//     every beat, tlast on 44, first tvalid 2 cycles after input tlast.
//  2) 1-byte pkt A5 -> single beat A5, tlast=1, tuser=1; s_tready=1 after handshake.
//  3) 10-byte pkt with m_tready toggled 1/0 each cycle -> all 10 bytes in order, no
//     repeats, outputs stable while stalled; s_tready=0 until final handshake.
//  4) 1473-byte pkt with MAX_BYTES=1472, macro undefined -> 1472-byte out pkt, tuser=1472,
//     drop_o pulse; 1473rd byte emitted as 1-byte next packet.
//  5) Same stimulus, macro defined -> no output, drop_o pulses once after input tlast;
//     following 3-byte pkt emitted with tuser=3.
//  6) rst_ni asserted mid-SEND (byte 3 of 8) -> outputs 0 at once; after release,
//     s_tready=1, and a new 2-byte pkt is output correctly with tuser=2.

Source files
------------

// File: rtl/axis_tx_pkt_buffer.sv
// Store-and-forward AXI-Stream byte buffer: captures one packet, then replays it with its byte count on tuser.
// Optional macro AXIS_TX_PKT_BUFFER_DROP_OVERSIZE_EN: discard oversize packets instead of truncating them.
module axis_tx_pkt_buffer #(
  parameter int MAX_BYTES = 1472,
  parameter int LEN_W     = 12
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             s_axis_tvalid_i,
  input  logic [7:0]       s_axis_tdata_i,
  input  logic             s_axis_tlast_i,
  output logic             s_axis_tready_o,
  output logic             m_axis_tvalid_o,
  output logic [7:0]       m_axis_tdata_o,
  output logic             m_axis_tlast_o,
  output logic [LEN_W-1:0] m_axis_tuser_o,
  input  logic             m_axis_tready_i,
  output logic             drop_o
);

  localparam int AW = (MAX_BYTES > 1) ? $clog2(MAX_BYTES) : 1;
  localparam logic [LEN_W-1:0] LP_LAST_IDX = LEN_W'(MAX_BYTES - 1);
  localparam logic [LEN_W-1:0] LP_ONE      = LEN_W'(1);

  typedef enum logic [1:0] {
    ST_FILL = 2'd0,
    ST_LOAD = 2'd1,
    ST_SEND = 2'd2,
    ST_DROP = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [7:0]       r_mem [0:MAX_BYTES-1];
  logic [7:0]       r_rd_data;
  logic [LEN_W-1:0] r_wr_ptr;
  logic [LEN_W-1:0] r_rd_ptr;
  logic [LEN_W-1:0] r_s1_idx;
  logic [LEN_W-1:0] r_len;
  logic             r_s1_vld;
  logic             r_s_ready;
  logic             r_out_vld;
  logic             r_out_last;
  logic [7:0]       r_out_data;
  logic             r_drop;

  logic w_s_hs;
  logic w_m_hs;
  logic w_m_done;
  logic w_wr_en;
  logic w_pkt_end;
  logic w_out_load;
  logic w_fetch;
  logic w_drop_pulse;
  logic w_s_ready_next;

  assign w_s_hs     = s_axis_tvalid_i && r_s_ready;
  assign w_m_hs     = r_out_vld && m_axis_tready_i;
  assign w_m_done   = w_m_hs && r_out_last;
  assign w_wr_en    = (r_state == ST_FILL) && w_s_hs;
  assign w_pkt_end  = w_wr_en && (s_axis_tlast_i || (r_wr_ptr == LP_LAST_IDX));
  // Stage 1 is the RAM read register; it refills whenever it is empty or moving into the output register.
  assign w_out_load = r_s1_vld && (!r_out_vld || m_axis_tready_i);
  assign w_fetch    = ((r_state == ST_LOAD) || (r_state == ST_SEND)) &&
                      (r_rd_ptr < r_len) && (!r_s1_vld || w_out_load);

  always_comb begin
    w_state_next = r_state;
    w_drop_pulse = 1'b0;
    case (r_state)
      ST_FILL: begin
        if (w_pkt_end) begin
`ifdef AXIS_TX_PKT_BUFFER_DROP_OVERSIZE_EN
          w_state_next = s_axis_tlast_i ? ST_LOAD : ST_DROP;
`else
          w_state_next = ST_LOAD;
          w_drop_pulse = !s_axis_tlast_i;
`endif
        end
      end
      ST_LOAD: w_state_next = ST_SEND;
      ST_SEND: begin
        if (w_m_done) w_state_next = ST_FILL;
      end
      ST_DROP: begin
`ifdef AXIS_TX_PKT_BUFFER_DROP_OVERSIZE_EN
        if (w_s_hs && s_axis_tlast_i) begin
          w_state_next = ST_FILL;
          w_drop_pulse = 1'b1;
        end
`else
        w_state_next = ST_FILL;
`endif
      end
      default: w_state_next = ST_FILL;
    endcase
  end

  assign w_s_ready_next = (w_state_next == ST_FILL) || (w_state_next == ST_DROP);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state   <= ST_FILL;
      r_s_ready <= 1'b0;
      r_drop    <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_s_ready <= w_s_ready_next;
      r_drop    <= w_drop_pulse;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wr_ptr <= '0;
      r_len    <= '0;
    end else begin
      if (w_wr_en) begin
        r_wr_ptr <= w_pkt_end ? '0 : (r_wr_ptr + LP_ONE);
      end
      if (w_pkt_end && (w_state_next == ST_LOAD)) begin
        r_len <= r_wr_ptr + LP_ONE;
      end else if (w_m_done) begin
        r_len <= '0;
      end
    end
  end

  // Storage and its read register carry no reset so they map onto block RAM.
  always_ff @(posedge clk_i) begin
    if (w_wr_en) begin
      r_mem[r_wr_ptr[AW-1:0]] <= s_axis_tdata_i;
    end
    if (w_fetch) begin
      r_rd_data <= r_mem[r_rd_ptr[AW-1:0]];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rd_ptr <= '0;
      r_s1_idx <= '0;
      r_s1_vld <= 1'b0;
    end else if (w_m_done) begin
      r_rd_ptr <= '0;
      r_s1_vld <= 1'b0;
    end else if (w_fetch) begin
      r_rd_ptr <= r_rd_ptr + LP_ONE;
      r_s1_idx <= r_rd_ptr;
      r_s1_vld <= 1'b1;
    end else if (w_out_load) begin
      r_s1_vld <= 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_out_vld  <= 1'b0;
      r_out_data <= '0;
      r_out_last <= 1'b0;
    end else if (w_out_load) begin
      r_out_vld  <= 1'b1;
      r_out_data <= r_rd_data;
      r_out_last <= (r_s1_idx == (r_len - LP_ONE));
    end else if (w_m_hs) begin
      r_out_vld  <= 1'b0;
      r_out_last <= 1'b0;
    end
  end

  assign s_axis_tready_o = r_s_ready;
  assign m_axis_tvalid_o = r_out_vld;
  assign m_axis_tdata_o  = r_out_data;
  assign m_axis_tlast_o  = r_out_last;
  assign m_axis_tuser_o  = r_len;
  assign drop_o          = r_drop;

endmodule

// File: tb/tb_axis_tx_pkt_buffer.sv
// Bench for axis_tx_pkt_buffer: vector table, randomized packet streams against a packet-level model,
// and a mid-packet reset sequence.
module tb_axis_tx_pkt_buffer;
  localparam int MAXB = 1472;
  localparam int LW   = 12;

  logic          clk;
  logic          rst_ni;
  logic          s_tvalid;
  logic [7:0]    s_tdata;
  logic          s_tlast;
  logic          s_tready;
  logic          m_tvalid;
  logic [7:0]    m_tdata;
  logic          m_tlast;
  logic [LW-1:0] m_tuser;
  logic          m_tready;
  logic          drop;

  typedef struct packed {
    logic [7:0]    d;
    logic          l;
    logic [LW-1:0] u;
  } beat_t;

  typedef struct {
    int         n;
    logic [7:0] base;
    logic [7:0] step;
    int         mode;
    bit         chk_lat;
    int         exp_beats;
    int         exp_pkts;
    int         exp_user0;
    int         exp_drops;
  } vec_t;

  int         total = 0;
  int         bad = 0;
  int         cyc = 0;
  int         m_mode = 0;
  bit         gap_en = 0;
  int         drop_cnt = 0;
  int         last_hs_cyc = 0;
  int         exp_drops = 0;
  logic [7:0] in_data_q[$];
  bit         in_last_q[$];
  beat_t      beats_q[$];
  beat_t      exp_q[$];
  int         rise_q[$];
  vec_t       tbl[6];

  axis_tx_pkt_buffer #(.MAX_BYTES(MAXB), .LEN_W(LW)) dut (
    .clk_i           (clk),
    .rst_ni          (rst_ni),
    .s_axis_tvalid_i (s_tvalid),
    .s_axis_tdata_i  (s_tdata),
    .s_axis_tlast_i  (s_tlast),
    .s_axis_tready_o (s_tready),
    .m_axis_tvalid_o (m_tvalid),
    .m_axis_tdata_o  (m_tdata),
    .m_axis_tlast_o  (m_tlast),
    .m_axis_tuser_o  (m_tuser),
    .m_axis_tready_i (m_tready),
    .drop_o          (drop)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Downstream ready pattern: 0 = always ready, 1 = toggle each cycle, 2 = random.
  initial begin
    m_tready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (m_mode)
        0:       m_tready = 1'b1;
        1:       m_tready = !m_tready;
        default: m_tready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Output monitor, sampled on the falling edge.
  initial begin
    bit    pv;
    bit    pr;
    bit    plast;
    beat_t pb;
    beat_t cur;
    pv = 0; pr = 0; plast = 0; pb = '0;
    forever begin
      @(negedge clk);
      if (!rst_ni) begin
        pv = 0; pr = 0; plast = 0;
      end else begin
        cur = '{d: m_tdata, l: m_tlast, u: m_tuser};
        if (drop) drop_cnt++;
        if (plast) begin
          chk("tvalid_after_last", 32'(m_tvalid), 32'd0);
          chk("s_tready_after_last", 32'(s_tready), 32'd1);
        end
        if (pv && !pr) begin
          chk("stall_valid", 32'(m_tvalid), 32'd1);
          chk("stall_hold", 32'(cur), 32'(pb));
        end
        if (m_tvalid && !pv) rise_q.push_back(cyc);
        if (m_tvalid) chk("single_buffer_s_tready", 32'(s_tready), 32'd0);
        plast = m_tvalid && m_tready && m_tlast;
        if (m_tvalid && m_tready) beats_q.push_back(cur);
        pv = m_tvalid; pr = m_tready; pb = cur;
      end
    end
  end

  // Packet-level reference: split the byte stream at tlast or at MAXB bytes.
  task automatic model_build();
    logic [7:0] cur[$];
    bit         discarding;
    discarding = 0;
    exp_q.delete();
    exp_drops = 0;
    foreach (in_data_q[i]) begin
      if (discarding) begin
        if (in_last_q[i]) begin
          discarding = 0;
          exp_drops++;
        end
      end else begin
        cur.push_back(in_data_q[i]);
        if (in_last_q[i] || cur.size() == MAXB) begin
          if (!in_last_q[i]) begin
`ifdef AXIS_TX_PKT_BUFFER_DROP_OVERSIZE_EN
            discarding = 1;
            cur.delete();
`else
            exp_drops++;
`endif
          end
          foreach (cur[j]) exp_q.push_back('{d: cur[j], l: (j == cur.size() - 1), u: LW'(cur.size())});
          cur.delete();
        end
      end
    end
  endtask

  task automatic drive_stream();
    int budget;
    @(posedge clk);
    #1;
    while (in_data_q.size() > 0) begin
      if (gap_en && $urandom_range(0, 3) == 0) begin
        s_tvalid = 1'b0;
        @(posedge clk);
        #1;
      end else begin
        s_tvalid = 1'b1;
        s_tdata  = in_data_q[0];
        s_tlast  = in_last_q[0];
        budget   = 0;
        @(negedge clk);
        while (!s_tready && budget < 5000) begin
          @(negedge clk);
          budget++;
        end
        if (!s_tready) begin
          chk("s_tready_wait", 32'(s_tready), 32'd1);
          in_data_q.delete();
          in_last_q.delete();
        end else begin
          @(posedge clk);
          #1;
          last_hs_cyc = cyc;
          void'(in_data_q.pop_front());
          void'(in_last_q.pop_front());
        end
      end
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic wait_beats(input int n, input int budget);
    int b;
    b = 0;
    while (beats_q.size() < n && b < budget) begin
      @(negedge clk);
      #1;
      b++;
    end
  endtask

  task automatic clear_run();
    beats_q.delete();
    rise_q.delete();
    in_data_q.delete();
    in_last_q.delete();
    drop_cnt = 0;
  endtask

  task automatic compare_beats(input string name);
    chk({name, "_count"}, 32'(beats_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < beats_q.size() && i < exp_q.size(); i++)
      chk($sformatf("%s_beat%0d", name, i), 32'(beats_q[i]), 32'(exp_q[i]));
    chk({name, "_drops"}, 32'(drop_cnt), 32'(exp_drops));
  endtask

  initial begin
    int npkts;
    tbl[0] = '{4,    8'h11, 8'h11, 0, 1'b1, 4,    1, 4,    0};
    tbl[1] = '{1,    8'hA5, 8'h00, 0, 1'b1, 1,    1, 1,    0};
    tbl[2] = '{10,   8'h30, 8'h01, 1, 1'b1, 10,   1, 10,   0};
    tbl[3] = '{1472, 8'h00, 8'h01, 2, 1'b1, 1472, 1, 1472, 0};
`ifdef AXIS_TX_PKT_BUFFER_DROP_OVERSIZE_EN
    tbl[4] = '{1473, 8'h80, 8'h01, 0, 1'b0, 0,    0, 0,    1};
`else
    tbl[4] = '{1473, 8'h80, 8'h01, 0, 1'b0, 1473, 2, 1472, 1};
`endif
    tbl[5] = '{3,    8'hC0, 8'h01, 0, 1'b1, 3,    1, 3,    0};

    rst_ni = 1'b0; s_tvalid = 1'b0; s_tdata = '0; s_tlast = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_s_tready", 32'(s_tready), 32'd0);
    chk("rst_m_tvalid", 32'(m_tvalid), 32'd0);
    chk("rst_m_tdata",  32'(m_tdata),  32'd0);
    chk("rst_m_tlast",  32'(m_tlast),  32'd0);
    chk("rst_m_tuser",  32'(m_tuser),  32'd0);
    chk("rst_drop",     32'(drop),     32'd0);
    @(negedge clk);
    rst_ni = 1'b1;
    #1;
    chk("rel_s_tready_same_cycle", 32'(s_tready), 32'd0);
    @(negedge clk);
    #1;
    chk("rel_s_tready_next_cycle", 32'(s_tready), 32'd1);

    for (int r = 0; r < 6; r++) begin
      clear_run();
      m_mode = tbl[r].mode;
      gap_en = 0;
      for (int k = 0; k < tbl[r].n; k++) begin
        in_data_q.push_back(8'(tbl[r].base + k * tbl[r].step));
        in_last_q.push_back(k == tbl[r].n - 1);
      end
      model_build();
      drive_stream();
      wait_beats(exp_q.size(), 8000);
      repeat (6) @(negedge clk);
      #1;
      npkts = 0;
      foreach (beats_q[i]) if (beats_q[i].l) npkts++;
      chk($sformatf("row%0d_beats", r), 32'(beats_q.size()), 32'(tbl[r].exp_beats));
      chk($sformatf("row%0d_pkts", r), 32'(npkts), 32'(tbl[r].exp_pkts));
      chk($sformatf("row%0d_drops", r), 32'(drop_cnt), 32'(tbl[r].exp_drops));
      if (tbl[r].exp_beats > 0)
        chk($sformatf("row%0d_user0", r), 32'(beats_q.size() > 0 ? int'(beats_q[0].u) : -1), 32'(tbl[r].exp_user0));
      if (tbl[r].chk_lat)
        chk($sformatf("row%0d_latency", r), 32'(rise_q.size() > 0 ? rise_q[0] : -1), 32'(last_hs_cyc + 2));
      compare_beats($sformatf("row%0d", r));
      $display("row %0d: in=%0d bytes out=%0d beats pkts=%0d drops=%0d", r, tbl[r].n, beats_q.size(), npkts, drop_cnt);
    end

    for (int b = 0; b < 2; b++) begin
      clear_run();
      m_mode = (b == 0) ? 1 : 2;
      gap_en = 1;
      for (int p = 0; p < 25; p++) begin
        int len;
        len = $urandom_range(1, 24);
        for (int k = 0; k < len; k++) begin
          in_data_q.push_back(8'($urandom));
          in_last_q.push_back(k == len - 1);
        end
      end
      model_build();
      drive_stream();
      wait_beats(exp_q.size(), 6000);
      repeat (6) @(negedge clk);
      #1;
      compare_beats($sformatf("rand%0d", b));
      $display("random batch %0d: out=%0d beats expected=%0d", b, beats_q.size(), exp_q.size());
    end

    // Reset while the third of eight bytes is presented, then a fresh 2-byte packet.
    clear_run();
    m_mode = 0;
    gap_en = 0;
    for (int k = 0; k < 8; k++) begin
      in_data_q.push_back(8'(8'hD0 + k));
      in_last_q.push_back(k == 7);
    end
    drive_stream();
    wait_beats(2, 200);
    chk("midrst_beats_before", 32'(beats_q.size()), 32'd2);
    @(posedge clk);
    #1;
    chk("midrst_presenting_byte3", 32'(m_tdata), 32'hD2);
    rst_ni = 1'b0;
    #1;
    chk("midrst_m_tvalid", 32'(m_tvalid), 32'd0);
    chk("midrst_m_tdata",  32'(m_tdata),  32'd0);
    chk("midrst_m_tlast",  32'(m_tlast),  32'd0);
    chk("midrst_m_tuser",  32'(m_tuser),  32'd0);
    chk("midrst_s_tready", 32'(s_tready), 32'd0);
    repeat (3) @(negedge clk);
    rst_ni = 1'b1;
    #1;
    chk("midrst_rel_s_tready0", 32'(s_tready), 32'd0);
    @(negedge clk);
    #1;
    chk("midrst_rel_s_tready1", 32'(s_tready), 32'd1);
    chk("midrst_rel_m_tvalid", 32'(m_tvalid), 32'd0);
    clear_run();
    in_data_q.push_back(8'hE1); in_last_q.push_back(1'b0);
    in_data_q.push_back(8'hE2); in_last_q.push_back(1'b1);
    model_build();
    drive_stream();
    wait_beats(exp_q.size(), 200);
    repeat (6) @(negedge clk);
    #1;
    compare_beats("after_rst");
    $display("after reset: out=%0d beats tuser0=%0d", beats_q.size(), beats_q.size() > 0 ? int'(beats_q[0].u) : -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
